pong_uart_cmd_decoder: RTL and testbench

//  Decodes keyboard bytes from the UART receiver into Pong control signals: game start plus P1/P2 paddle up/down.

---
 rtl/pong_cmd_pkg.sv | 24 ++
 rtl/pong_hold_timer.sv | 38 +++
 rtl/pong_uart_cmd_decoder.sv | 124 ++++++++++++
 tb/tb_pong_uart_cmd_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pong_cmd_pkg.sv
// pong_cmd_pkg: shared constants and encodings for the Pong UART command decoder
//   ASCII key codes, escape-FSM state encoding, paddle direction encoding.
package pong_cmd_pkg;
    localparam logic [7:0] KEY_W        = 8'h77;
    localparam logic [7:0] KEY_S        = 8'h73;
    localparam logic [7:0] KEY_I        = 8'h69;
    localparam logic [7:0] KEY_K        = 8'h6B;
    localparam logic [7:0] KEY_SPACE    = 8'h20;
    localparam logic [7:0] KEY_CR       = 8'h0D;
    localparam logic [7:0] KEY_ESC      = 8'h1B;
    localparam logic [7:0] KEY_LBRACKET = 8'h5B;
    localparam logic [7:0] KEY_A        = 8'h41;
    localparam logic [7:0] KEY_B        = 8'h42;
    localparam logic [7:0] KEY_C        = 8'h43;
    localparam logic [7:0] KEY_D        = 8'h44;

    typedef enum logic [1:0] {IDLE, ESC_SEEN, CSI} state_t;
    typedef enum logic [1:0] {NONE, UP, DN} dir_t;

    // Folds an ASCII letter to lower case; only meaningful when compared against a lower-case letter.
    function automatic logic [7:0] to_lower(input logic [7:0] b);
        return b | 8'h20;
    endfunction
endpackage

// File: rtl/pong_hold_timer.sv
// pong_hold_timer: holds one paddle's up/down level for CLKS_PER_HOLD cycles after each load
//   i_Clk, i_Rst_L (async active-low) ; i_Load strobe ; i_Dir (UP/DN) ; o_Up, o_Dn registered levels
module pong_hold_timer
    import pong_cmd_pkg::*;
#(
    parameter int CLKS_PER_HOLD = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Load,
    input  logic [1:0] i_Dir,
    output logic       o_Up,
    output logic       o_Dn
);
    localparam int W = $clog2(CLKS_PER_HOLD + 1);
    localparam logic [W-1:0] HOLD = W'(CLKS_PER_HOLD);

    logic [W-1:0] cnt;

    // A load always overwrites direction, so up and down can never be high together.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt  <= '0;
            o_Up <= 1'b0;
            o_Dn <= 1'b0;
        end else if (i_Load) begin
            cnt  <= HOLD;
            o_Up <= i_Dir == UP;
            o_Dn <= i_Dir == DN;
        end else if (cnt > W'(1)) begin
            cnt  <= cnt - W'(1);
        end else begin
            cnt  <= '0;
            o_Up <= 1'b0;
            o_Dn <= 1'b0;
        end
    end
endmodule

// File: rtl/pong_uart_cmd_decoder.sv
// pong_uart_cmd_decoder: turns UART keyboard bytes into Pong start/paddle controls
//   i_Clk, i_Rst_L (async active-low) ; i_RX_DV/i_RX_Byte from UART_RX
//   o_Game_Start, o_Cmd_Err one-cycle pulses ; o_Paddle_{Up,Dn}_P{1,2} held levels
//   PONG_CMD_ECHO_EN adds o_Echo_DV/o_Echo_Byte copying every byte that raised a control output
module pong_uart_cmd_decoder
    import pong_cmd_pkg::*;
#(
    parameter int CLKS_PER_HOLD    = 2500000,
    parameter int ESC_TIMEOUT_CLKS = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Game_Start,
    output logic       o_Paddle_Up_P1,
    output logic       o_Paddle_Dn_P1,
    output logic       o_Paddle_Up_P2,
    output logic       o_Paddle_Dn_P2,
`ifdef PONG_CMD_ECHO_EN
    output logic       o_Echo_DV,
    output logic [7:0] o_Echo_Byte,
`endif
    output logic       o_Cmd_Err
);
    localparam int TW = $clog2(ESC_TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO = TW'(ESC_TIMEOUT_CLKS);

    state_t        state, nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    dir_t          p1_dir, p2_dir;
    logic          start, err;
    logic [7:0]    lc;

    assign lc = to_lower(i_RX_Byte);

    always_comb begin
        p1_dir  = NONE;
        p2_dir  = NONE;
        start   = 1'b0;
        err     = 1'b0;
        nxt     = state;
        tmo_nxt = tmo;
        if (i_RX_DV) begin
            // A byte always wins over timer expiry and is judged in the current state.
            nxt     = IDLE;
            tmo_nxt = '0;
            case (state)
                IDLE: begin
                    if (lc == KEY_W) p1_dir = UP;
                    else if (lc == KEY_S) p1_dir = DN;
                    else if (lc == KEY_I) p2_dir = UP;
                    else if (lc == KEY_K) p2_dir = DN;
                    else if (i_RX_Byte == KEY_SPACE || i_RX_Byte == KEY_CR) start = 1'b1;
                    else if (i_RX_Byte == KEY_ESC) begin
                        nxt     = ESC_SEEN;
                        tmo_nxt = TMO;
                    end else err = 1'b1;
                end
                ESC_SEEN: begin
                    if (i_RX_Byte == KEY_LBRACKET || i_RX_Byte == KEY_ESC) begin
                        nxt     = i_RX_Byte == KEY_ESC ? ESC_SEEN : CSI;
                        tmo_nxt = TMO;
                    end else err = 1'b1;
                end
                default: begin
                    if (i_RX_Byte == KEY_A) p2_dir = UP;
                    else if (i_RX_Byte == KEY_B) p2_dir = DN;
                    else if (i_RX_Byte != KEY_C && i_RX_Byte != KEY_D) err = 1'b1;
                end
            endcase
        end else if (state != IDLE) begin
            nxt     = tmo > TW'(1) ? state : IDLE;
            tmo_nxt = tmo > TW'(1) ? tmo - TW'(1) : '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            tmo          <= '0;
            o_Game_Start <= 1'b0;
            o_Cmd_Err    <= 1'b0;
        end else begin
            state        <= nxt;
            tmo          <= tmo_nxt;
            o_Game_Start <= start;
            o_Cmd_Err    <= err;
        end
    end

`ifdef PONG_CMD_ECHO_EN
    logic hit;
    assign hit = p1_dir != NONE || p2_dir != NONE || start;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Echo_DV   <= 1'b0;
            o_Echo_Byte <= '0;
        end else begin
            o_Echo_DV   <= hit;
            o_Echo_Byte <= hit ? i_RX_Byte : o_Echo_Byte;
        end
    end
`endif

    pong_hold_timer #(.CLKS_PER_HOLD(CLKS_PER_HOLD)) u_p1 (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Load (p1_dir != NONE),
        .i_Dir  (p1_dir),
        .o_Up   (o_Paddle_Up_P1),
        .o_Dn   (o_Paddle_Dn_P1)
    );

    pong_hold_timer #(.CLKS_PER_HOLD(CLKS_PER_HOLD)) u_p2 (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Load (p2_dir != NONE),
        .i_Dir  (p2_dir),
        .o_Up   (o_Paddle_Up_P2),
        .o_Dn   (o_Paddle_Dn_P2)
    );
endmodule

// File: tb/tb_pong_uart_cmd_decoder.sv
// tb_pong_uart_cmd_decoder: scoreboard bench for pong_uart_cmd_decoder against a timeline reference model
module tb_pong_uart_cmd_decoder;
    localparam int HOLD = 8;
    localparam int ESC  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] rx = 8'h00;
    logic       start, u1, d1, u2, d2, err;
`ifdef PONG_CMD_ECHO_EN
    logic       edv;
    logic [7:0] eb;
`endif

    pong_uart_cmd_decoder #(.CLKS_PER_HOLD(HOLD), .ESC_TIMEOUT_CLKS(ESC)) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_RX_DV       (dv),
        .i_RX_Byte     (rx),
        .o_Game_Start  (start),
        .o_Paddle_Up_P1(u1),
        .o_Paddle_Dn_P1(d1),
        .o_Paddle_Up_P2(u2),
        .o_Paddle_Dn_P2(d2),
`ifdef PONG_CMD_ECHO_EN
        .o_Echo_DV     (edv),
        .o_Echo_Byte   (eb),
`endif
        .o_Cmd_Err     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [14:0] q[$];

    // Reference model: each paddle remembers its direction and the last cycle it stays high;
    // the escape parser remembers its mode and the cycle of the last byte it accepted.
    int cyc = 0;
    int p1d = 0, p1e = -1, p2d = 0, p2e = -1;
    int mode = 0, last = 0;

    always @(posedge clk) begin : model
        logic [14:0] e;
        logic s_e, r_e, ec;
        int t;
        t = cyc;
        s_e = 1'b0;
        r_e = 1'b0;
        ec = 1'b0;
        e = '0;
        if (!rst_n) begin
            p1d = 0;
            p2d = 0;
            mode = 0;
        end else begin
            if (mode != 0 && t - last > ESC) mode = 0;
            if (dv) begin
                if (mode == 0) begin
                    case (rx)
                        "w", "W": begin p1d = 1; p1e = t + HOLD; ec = 1'b1; end
                        "s", "S": begin p1d = 2; p1e = t + HOLD; ec = 1'b1; end
                        "i", "I": begin p2d = 1; p2e = t + HOLD; ec = 1'b1; end
                        "k", "K": begin p2d = 2; p2e = t + HOLD; ec = 1'b1; end
                        8'h20, 8'h0D: begin s_e = 1'b1; ec = 1'b1; end
                        8'h1B: begin mode = 1; last = t; end
                        default: r_e = 1'b1;
                    endcase
                end else if (mode == 1) begin
                    if (rx == "[") begin mode = 2; last = t; end
                    else if (rx == 8'h1B) last = t;
                    else begin mode = 0; r_e = 1'b1; end
                end else begin
                    mode = 0;
                    if (rx == "A") begin p2d = 1; p2e = t + HOLD; ec = 1'b1; end
                    else if (rx == "B") begin p2d = 2; p2e = t + HOLD; ec = 1'b1; end
                    else if (rx != "C" && rx != "D") r_e = 1'b1;
                end
            end
            e[5] = s_e;
            e[4] = p1d == 1 && t + 1 <= p1e;
            e[3] = p1d == 2 && t + 1 <= p1e;
            e[2] = p2d == 1 && t + 1 <= p2e;
            e[1] = p2d == 2 && t + 1 <= p2e;
            e[0] = r_e;
`ifdef PONG_CMD_ECHO_EN
            e[6] = ec;
            e[14:7] = ec ? rx : 8'h00;
`endif
        end
        q.push_back(e);
        cyc++;
    end

    always @(negedge clk) begin : monitor
        logic [14:0] a, x;
        if (q.size() == 0) begin
            if (cyc > 0) begin
                checks++;
                fails++;
                $display("FAIL scoreboard_empty cycle %0d: no expected entry", cyc);
            end
        end else begin
            x = q.pop_front();
            a = {9'b0, start, u1, d1, u2, d2, err};
`ifdef PONG_CMD_ECHO_EN
            a[6] = edv;
            a[14:7] = eb & {8{x[6]}};
`endif
            checks++;
            if (a !== x) begin
                fails++;
                $display("FAIL outputs cycle %0d: actual %h required %h", cyc, a, x);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        dv = 1'b1;
        rx = b;
        @(posedge clk);
        #1 dv = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] pool [18] = '{"w", "W", "s", "S", "i", "I", "k", "K", 8'h20, 8'h0D,
                              8'h1B, "[", "A", "B", "C", "D", "x", 8'h00};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        send("w", 12);
        send("w", 4);  send("w", 14);
        send("w", 2);  send("s", 12);
        send(8'h1B, 0); send("[", 0); send("A", 10);
        send(8'h1B, 6); send("A", 10);
        send(8'h1B, 3); send("[", 3); send("B", 10);
        send(8'h1B, 1); send(8'h1B, 0); send("[", 0); send("C", 3);
        send(8'h20, 3);
        send("x", 3);
        send("k", 10);
        send(8'h1B, 0); send("[", 0); send("B", 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({start, u1, d1, u2, d2, err} !== 6'b0) begin
            fails++;
            $display("FAIL async_reset: actual %b required 000000", {start, u1, d1, u2, d2, err});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send("A", 4);
        for (int n = 0; n < 500; n++) begin
            int idx;
            logic [7:0] b;
            idx = $urandom_range(0, 17);
            b = idx == 17 ? 8'($urandom_range(0, 255)) : pool[idx];
            send(b, $urandom_range(0, 3) == 0 ? $urandom_range(0, 12) : $urandom_range(0, 2));
        end
        repeat (12) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
